// File: rtl/fwd_net.sv
// fwd_net: bypass network that picks the youngest producer for each ID read port and flags load-use stalls.
// Latency: stallreq_for_load is combinational; the forward select and data appear on fwd_*_r one cycle later (EX).
// Backpressure: stall_id/stall_ex hold the registered outputs or insert a bubble; flush clears them.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush, stall_id, stall_ex pipeline control for the ID->EX registers
//   rd_valid, rd_addr         NRD read ports in ID (port i at rd_addr[i*ADDR_W +: ADDR_W])
//   src_we, src_waddr,
//   src_wdata, src_is_load    NSRC producers, index 0 = youngest (EX)
//   stallreq_for_load         a read port's youngest matching producer is a pending load
//   fwd_sel_r, fwd_data_r     registered per-port forward select and data
//   fwd_hit_cnt,
//   load_stall_cnt            saturating performance counters
module fwd_net #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NSRC   = 3,
  parameter int NRD    = 2,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall_id,
  input  logic                   stall_ex,
  input  logic [NRD-1:0]         rd_valid,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  input  logic [NSRC-1:0]        src_we,
  input  logic [NSRC*ADDR_W-1:0] src_waddr,
  input  logic [NSRC*DATA_W-1:0] src_wdata,
  input  logic [NSRC-1:0]        src_is_load,
  output logic                   stallreq_for_load,
  output logic [NRD-1:0]         fwd_sel_r,
  output logic [NRD*DATA_W-1:0]  fwd_data_r,
  output logic [CNT_W-1:0]       fwd_hit_cnt,
  output logic [CNT_W-1:0]       load_stall_cnt
);

  logic [NRD-1:0]        next_sel;
  logic [NRD*DATA_W-1:0] next_data;
  logic [NRD-1:0]        load_blocked;
  logic [CNT_W-1:0]      hit_inc;
  logic [CNT_W:0]        hit_sum;
  logic [CNT_W:0]        ls_sum;

  // Producers are scanned oldest to youngest so that the youngest match
  // overwrites any older one; a younger pending load therefore always wins
  // over an older ready result.
  always_comb begin
    next_sel     = '0;
    next_data    = '0;
    load_blocked = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int s = NSRC - 1; s >= 0; s--) begin
        if (rd_valid[i] && src_we[s] &&
            (src_waddr[s*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W]) &&
            (rd_addr[i*ADDR_W +: ADDR_W] != '0)) begin
          if (src_is_load[s]) begin
            load_blocked[i]              = 1'b1;
            next_sel[i]                  = 1'b0;
            next_data[i*DATA_W +: DATA_W] = '0;
          end else begin
            load_blocked[i]              = 1'b0;
            next_sel[i]                  = 1'b1;
            next_data[i*DATA_W +: DATA_W] = src_wdata[s*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign stallreq_for_load = |load_blocked;

  always_comb begin
    hit_inc = '0;
    for (int i = 0; i < NRD; i++) begin
      hit_inc = hit_inc + CNT_W'(next_sel[i]);
    end
  end

  // One extra bit catches the carry; a carry out means saturate.
  assign hit_sum = {1'b0, fwd_hit_cnt} + {1'b0, hit_inc};
  assign ls_sum  = {1'b0, load_stall_cnt} + {{CNT_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_sel_r  <= '0;
      fwd_data_r <= '0;
    end else if (flush) begin
      fwd_sel_r  <= '0;
      fwd_data_r <= '0;
    end else if (stall_id && !stall_ex) begin
      fwd_sel_r  <= '0;
      fwd_data_r <= '0;
    end else if (!stall_id) begin
      fwd_sel_r  <= next_sel;
      fwd_data_r <= next_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit_cnt    <= '0;
      load_stall_cnt <= '0;
    end else begin
      if (!flush && !stall_id) begin
        fwd_hit_cnt <= hit_sum[CNT_W] ? {CNT_W{1'b1}} : hit_sum[CNT_W-1:0];
      end
      if (stallreq_for_load) begin
        load_stall_cnt <= ls_sum[CNT_W] ? {CNT_W{1'b1}} : ls_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fwd_net.sv
// tb_fwd_net: directed vectors for fwd_net with a queue-based scoreboard.
// Two instances share stimulus: default widths and a CNT_W=4 build for counter saturation.
module tb_fwd_net;

  logic        clk = 1'b0;
  logic        rst, flush, stall_id, stall_ex;
  logic [1:0]  rd_valid;
  logic [9:0]  rd_addr;
  logic [2:0]  src_we;
  logic [14:0] src_waddr;
  logic [95:0] src_wdata;
  logic [2:0]  src_is_load;

  logic        stallreq, stallreq4;
  logic [1:0]  sel, sel4;
  logic [63:0] data, data4;
  logic [31:0] hit_cnt, ls_cnt;
  logic [3:0]  hit_cnt4, ls_cnt4;

  always #5 clk = ~clk;

  fwd_net dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id), .stall_ex(stall_ex),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .src_we(src_we), .src_waddr(src_waddr),
    .src_wdata(src_wdata), .src_is_load(src_is_load), .stallreq_for_load(stallreq),
    .fwd_sel_r(sel), .fwd_data_r(data), .fwd_hit_cnt(hit_cnt), .load_stall_cnt(ls_cnt)
  );

  fwd_net #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id), .stall_ex(stall_ex),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .src_we(src_we), .src_waddr(src_waddr),
    .src_wdata(src_wdata), .src_is_load(src_is_load), .stallreq_for_load(stallreq4),
    .fwd_sel_r(sel4), .fwd_data_r(data4), .fwd_hit_cnt(hit_cnt4), .load_stall_cnt(ls_cnt4)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] d0;
    logic [31:0] d1;
    int          h;
    int          l;
  } exp_t;

  exp_t q_reg[$];
  logic q_comb[$];
  int   tests = 0;
  int   fails = 0;
  int   step_no = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, step_no, act, exp);
    end
  endtask

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue what the DUT must show.
  task automatic step(
    input logic r, input logic f, input logic sid, input logic sex,
    input logic [1:0] rv, input logic [4:0] a0, input logic [4:0] a1,
    input logic [2:0] we, input logic [4:0] w0, input logic [4:0] w1, input logic [4:0] w2,
    input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [2:0] ld,
    input logic e_st, input logic [1:0] e_sel, input logic [31:0] e_d0, input logic [31:0] e_d1,
    input int e_h, input int e_l);
    exp_t e;
    @(negedge clk);
    step_no++;
    rst = r; flush = f; stall_id = sid; stall_ex = sex;
    rd_valid = rv; rd_addr = {a1, a0};
    src_we = we; src_waddr = {w2, w1, w0}; src_wdata = {d2, d1, d0}; src_is_load = ld;
    e.sel = e_sel; e.d0 = e_d0; e.d1 = e_d1; e.h = e_h; e.l = e_l;
    q_comb.push_back(e_st);
    q_reg.push_back(e);
  endtask

  // Combinational monitor: inputs settle after the falling edge.
  initial begin
    forever begin
      logic es;
      @(negedge clk);
      #2;
      if (q_comb.size() > 0) begin
        es = q_comb.pop_front();
        chk("stallreq_for_load", {63'd0, stallreq}, {63'd0, es});
        chk("stallreq_for_load_w4", {63'd0, stallreq4}, {63'd0, es});
      end
    end
  end

  // Registered monitor: checks the state captured at the rising edge.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q_reg.size() > 0) begin
        e = q_reg.pop_front();
        chk("fwd_sel_r", {62'd0, sel}, {62'd0, e.sel});
        chk("fwd_data_r0", {32'd0, data[31:0]}, {32'd0, e.d0});
        chk("fwd_data_r1", {32'd0, data[63:32]}, {32'd0, e.d1});
        chk("fwd_hit_cnt", {32'd0, hit_cnt}, 64'(e.h));
        chk("load_stall_cnt", {32'd0, ls_cnt}, 64'(e.l));
        chk("fwd_sel_r_w4", {62'd0, sel4}, {62'd0, e.sel});
        chk("fwd_hit_cnt_w4", {60'd0, hit_cnt4}, 64'(sat4(e.h)));
        chk("load_stall_cnt_w4", {60'd0, ls_cnt4}, 64'(sat4(e.l)));
      end
    end
  end

  initial begin
    int wait_cyc;
    rst = 1'b1; flush = 1'b0; stall_id = 1'b0; stall_ex = 1'b0;
    rd_valid = '0; rd_addr = '0; src_we = '0; src_waddr = '0; src_wdata = '0; src_is_load = '0;
    //    r f si se rv    a0 a1  we    w0 w1 w2  d0            d1        d2        ld      st sel   ed0          ed1       h  l
    step(1,0,0,0,2'b00, 0, 0, 3'b000, 0, 0, 0, 32'h0,        32'h0,    32'h0,    3'b000, 0,2'b00,32'h0,       32'h0,    0, 0);
    // simple forward from EX
    step(0,0,0,0,2'b01, 8, 0, 3'b001, 8, 0, 0, 32'h1234,     32'h0,    32'h0,    3'b000, 0,2'b01,32'h1234,    32'h0,    1, 0);
    // youngest of two matches wins
    step(0,0,0,0,2'b01, 9, 0, 3'b101, 9, 0, 9, 32'hAAAA,     32'h0,    32'hBBBB, 3'b000, 0,2'b01,32'hAAAA,    32'h0,    2, 0);
    // younger load blocks older ready result
    step(0,0,0,0,2'b10, 0, 5, 3'b011, 5, 5, 0, 32'h0,        32'h77,   32'h0,    3'b001, 1,2'b00,32'h0,       32'h0,    2, 1);
    // $0 never matches, even from a load
    step(0,0,0,0,2'b11, 0, 0, 3'b001, 0, 0, 0, 32'hDEAD,     32'h0,    32'h0,    3'b001, 0,2'b00,32'h0,       32'h0,    2, 1);
    // capture 0x55, then hold for three cycles while sources change
    step(0,0,0,0,2'b01, 3, 0, 3'b010, 0, 3, 0, 32'h0,        32'h55,   32'h0,    3'b000, 0,2'b01,32'h55,      32'h0,    3, 1);
    step(0,0,1,1,2'b11, 3, 3, 3'b001, 3, 0, 0, 32'h99,       32'h0,    32'h0,    3'b000, 0,2'b01,32'h55,      32'h0,    3, 1);
    step(0,0,1,1,2'b11, 3, 3, 3'b001, 3, 0, 0, 32'h98,       32'h0,    32'h0,    3'b000, 0,2'b01,32'h55,      32'h0,    3, 1);
    step(0,0,1,1,2'b11, 3, 3, 3'b001, 3, 0, 0, 32'h97,       32'h0,    32'h0,    3'b001, 1,2'b01,32'h55,      32'h0,    3, 2);
    // bubble into EX
    step(0,0,1,0,2'b01, 3, 0, 3'b010, 0, 3, 0, 32'h0,        32'h66,   32'h0,    3'b000, 0,2'b00,32'h0,       32'h0,    3, 2);
    // flush with a live match, then flush during a load-use
    step(0,1,0,0,2'b01, 4, 0, 3'b001, 4, 0, 0, 32'h44,       32'h0,    32'h0,    3'b000, 0,2'b00,32'h0,       32'h0,    3, 2);
    step(0,1,0,0,2'b01, 4, 0, 3'b001, 4, 0, 0, 32'h44,       32'h0,    32'h0,    3'b001, 1,2'b00,32'h0,       32'h0,    3, 3);
    // one producer feeds both ports
    step(0,0,0,0,2'b11, 7, 7, 3'b100, 0, 0, 7, 32'h0,        32'h0,    32'h700,  3'b000, 0,2'b11,32'h700,     32'h700,  5, 3);
    // port0 load-blocked, port1 forwarded from the oldest stage
    step(0,0,0,0,2'b11, 6,10, 3'b111, 6, 6,10, 32'h0,        32'h61,   32'hA0,   3'b001, 1,2'b10,32'h0,       32'hA0,   6, 4);
    // unused read port never forwards
    step(0,0,0,0,2'b00, 8, 0, 3'b001, 8, 0, 0, 32'h1,        32'h0,    32'h0,    3'b000, 0,2'b00,32'h0,       32'h0,    6, 4);
    // repeated dual hits drive the 4-bit counter into saturation
    for (int k = 0; k < 10; k++) begin
      step(0,0,0,0,2'b11, 2, 2, 3'b001, 2, 0, 0, 32'h22,     32'h0,    32'h0,    3'b000, 0,2'b11,32'h22,      32'h22,   6 + 2*(k+1), 4);
    end
    // reset mid-operation clears everything, stall request stays combinational
    step(1,0,0,0,2'b11, 2, 2, 3'b001, 2, 0, 0, 32'h22,       32'h0,    32'h0,    3'b001, 1,2'b00,32'h0,       32'h0,    0, 0);
    step(0,0,0,0,2'b00, 0, 0, 3'b000, 0, 0, 0, 32'h0,        32'h0,    32'h0,    3'b000, 0,2'b00,32'h0,       32'h0,    0, 0);

    wait_cyc = 0;
    while ((q_reg.size() > 0 || q_comb.size() > 0) && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(negedge clk);
    chk("scoreboard_drained", 64'(q_reg.size() + q_comb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
